sr_shift_tx: RTL and testbench

- Serial transmitter for the display shift-register chain; the far end of the controller's load/busy/latch handshake.
- Captures a parallel segment/digit word on a one-cycle load strobe and shifts it out MSB-first on a data/shift-clock pair.
- Reports busy while transmitting, and generates the storage-register clock pulse (rclk) on a latch request.
- Sits between the display controller/digit mux and the off-chip 74HC595-style register chain.

---
 rtl/display_pkg.sv | 22 ++
 rtl/sr_shift_tx_if.sv | 27 ++
 rtl/sr_tick_div.sv | 25 ++
 rtl/sr_shift_tx.sv | 163 ++++++++++++++++
 tb/tb_sr_shift_tx.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Definitions shared by the display controller and the shift-register transmitter
// so both ends agree on the word width and the serial FSM encoding.
package display_pkg;

    localparam int DISP_WIDTH  = 8;

    localparam int CLKDIV_MIN  = 1;
    localparam int CLKDIV_MAX  = 255;
    localparam int LATCH_W_MIN = 1;
    localparam int LATCH_W_MAX = 15;

    // Wide enough for the longest CLKDIV or LATCH_W phase.
    localparam int DIV_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } sr_state_e;

endpackage

// File: rtl/sr_shift_tx_if.sv
// Load/busy/latch handshake between the display controller and the serial transmitter,
// plus the serial pins the transmitter drives toward the register chain.
interface sr_shift_tx_if
    import display_pkg::*;
#(
    parameter int WIDTH = DISP_WIDTH
);
    logic [WIDTH-1:0] i_data;
    logic             i_load;
    logic             i_latch;
    logic             i_blank;
    logic             o_busy;
    logic             o_sdata;
    logic             o_sclk;
    logic             o_rclk;
    logic             o_ovf;

    modport master (
        output i_data, i_load, i_latch, i_blank,
        input  o_busy, o_sdata, o_sclk, o_rclk, o_ovf
    );

    modport slave (
        input  i_data, i_load, i_latch, i_blank,
        output o_busy, o_sdata, o_sclk, o_rclk, o_ovf
    );
endinterface

// File: rtl/sr_tick_div.sv
// Loadable down-counter; o_tc is high while the count sits at zero, i.e. in the
// last cycle of a phase that was loaded with (length - 1).
module sr_tick_div #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/sr_shift_tx.sv
// Serial transmitter for a 74HC595-style chain: shifts a captured word out MSB-first
// on sdata/sclk and issues the storage-register clock pulse on a latch request.
module sr_shift_tx
    import display_pkg::*;
#(
    parameter int WIDTH   = DISP_WIDTH,
    parameter int CLKDIV  = 2,
    parameter int LATCH_W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    sr_shift_tx_if.slave bus
);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sr_state_e        r_state;
    sr_state_e        w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_bit_cnt_next;
    logic [WIDTH-1:0] r_pend_word;
    logic [WIDTH-1:0] w_pend_word_next;
    logic             r_load_pend;
    logic             w_load_pend_next;
    logic             r_latch_pend;
    logic             w_latch_pend_next;
    logic             r_ovf;
    logic             w_ovf_next;
    logic [WIDTH-1:0] w_word;

    logic             r_busy;
    logic             r_sdata;
    logic             r_sclk;
    logic             r_rclk;

    logic             w_div_load;
    logic [DIV_W-1:0] w_div_val;
    logic             w_tc;

    // Every state change restarts the phase timer, so no divider phase leaks across words.
    assign w_div_load = (w_state_next != r_state);
    assign w_div_val  = (w_state_next == LATCH) ? DIV_W'(LATCH_W - 1) : DIV_W'(CLKDIV - 1);

    sr_tick_div #(
        .CNT_W (DIV_W)
    ) u_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_div_load),
        .i_val  (w_div_val),
        .o_tc   (w_tc)
    );

    assign w_word = bus.i_blank ? '0 : bus.i_data;

    always_comb begin
        w_state_next      = r_state;
        w_shreg_next      = r_shreg;
        w_bit_cnt_next    = r_bit_cnt;
        w_pend_word_next  = r_pend_word;
        w_load_pend_next  = r_load_pend;
        w_latch_pend_next = r_latch_pend;
        w_ovf_next        = r_ovf;

        unique case (r_state)
            IDLE: begin
                if (bus.i_latch) begin
                    w_state_next = LATCH;
                    if (bus.i_load) begin
                        w_pend_word_next = w_word;
                        w_load_pend_next = 1'b1;
                    end
                end else if (bus.i_load) begin
                    w_state_next   = LOW;
                    w_shreg_next   = w_word;
                    w_bit_cnt_next = BIT_W'(WIDTH - 1);
                end
            end
            LOW: begin
                if (bus.i_latch) begin
                    w_latch_pend_next = 1'b1;
                end
                if (w_tc) begin
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                if (bus.i_latch) begin
                    w_latch_pend_next = 1'b1;
                end
                if (w_tc) begin
                    if (r_bit_cnt != '0) begin
                        w_shreg_next   = {r_shreg[WIDTH-2:0], 1'b0};
                        w_bit_cnt_next = r_bit_cnt - BIT_W'(1);
                        w_state_next   = LOW;
                    end else if (r_latch_pend || bus.i_latch) begin
                        // A request arriving in the very last HIGH cycle still chains on.
                        w_latch_pend_next = 1'b0;
                        w_state_next      = LATCH;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            LATCH: begin
                if (w_tc) begin
                    if (r_load_pend) begin
                        w_shreg_next     = r_pend_word;
                        w_bit_cnt_next   = BIT_W'(WIDTH - 1);
                        w_load_pend_next = 1'b0;
                        w_state_next     = LOW;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (bus.i_load && (r_state != IDLE)) begin
            w_ovf_next = 1'b1;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_pend_word  <= '0;
            r_load_pend  <= 1'b0;
            r_latch_pend <= 1'b0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
            r_sdata      <= 1'b0;
            r_sclk       <= 1'b0;
            r_rclk       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shreg      <= w_shreg_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_pend_word  <= w_pend_word_next;
            r_load_pend  <= w_load_pend_next;
            r_latch_pend <= w_latch_pend_next;
            r_ovf        <= w_ovf_next;
            r_busy       <= (w_state_next != IDLE);
            r_sclk       <= (w_state_next == HIGH);
            r_rclk       <= (w_state_next == LATCH);
            r_sdata      <= ((w_state_next == LOW) || (w_state_next == HIGH))
                            ? w_shreg_next[WIDTH-1] : 1'b0;
        end
    end

    assign bus.o_busy  = r_busy;
    assign bus.o_sdata = r_sdata;
    assign bus.o_sclk  = r_sclk;
    assign bus.o_rclk  = r_rclk;
    assign bus.o_ovf   = r_ovf;
endmodule

// File: tb/tb_sr_shift_tx.sv
// Directed bench for sr_shift_tx with WIDTH=8, CLKDIV=2, LATCH_W=2.
module tb_sr_shift_tx;
    logic clk;
    logic rst;

    sr_shift_tx_if #(.WIDTH(8)) bus_if ();

    sr_shift_tx #(
        .WIDTH   (8),
        .CLKDIV  (2),
        .LATCH_W (2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    int       c_busy, c_busy_first, c_busy_last;
    int       c_rclk, c_rclk_first, c_rclk_last;
    int       c_sclk_hi, c_edges;
    int       c_t [16];
    logic [7:0] c_word;
    logic [3:0] c_snap;
    logic     c_end_sdata, c_end_sclk, c_end_ovf;

    // Runs ncyc clock edges; the caller sets strobes for edge 0, and one extra
    // event (1=latch, 2=load of inj_data, 3=reset) may be injected at edge inj_cyc.
    task automatic collect(input int ncyc, input int inj_cyc, input int inj_kind,
                           input logic [7:0] inj_data);
        logic prev;
        c_busy = 0; c_busy_first = -1; c_busy_last = -1;
        c_rclk = 0; c_rclk_first = -1; c_rclk_last = -1;
        c_sclk_hi = 0; c_edges = 0; c_word = 8'h00; c_snap = 4'hF;
        for (int k = 0; k < 16; k++) c_t[k] = -1;
        prev = bus_if.o_sclk;
        for (int i = 0; i < ncyc; i++) begin
            if (i == inj_cyc) begin
                case (inj_kind)
                    1: bus_if.i_latch = 1'b1;
                    2: begin bus_if.i_load = 1'b1; bus_if.i_data = inj_data; end
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            @(posedge clk); #1;
            bus_if.i_load  = 1'b0;
            bus_if.i_latch = 1'b0;
            bus_if.i_blank = 1'b0;
            rst            = 1'b0;
            if (i == inj_cyc)
                c_snap = {bus_if.o_busy, bus_if.o_sclk, bus_if.o_rclk, bus_if.o_ovf};
            if (bus_if.o_busy === 1'b1) begin
                c_busy++;
                if (c_busy_first < 0) c_busy_first = i;
                c_busy_last = i;
            end
            if (bus_if.o_rclk === 1'b1) begin
                c_rclk++;
                if (c_rclk_first < 0) c_rclk_first = i;
                c_rclk_last = i;
            end
            if (bus_if.o_sclk === 1'b1) c_sclk_hi++;
            if (bus_if.o_sclk === 1'b1 && prev !== 1'b1) begin
                if (c_edges < 8) c_word = {c_word[6:0], bus_if.o_sdata};
                if (c_edges < 16) c_t[c_edges] = i;
                c_edges++;
            end
            prev = bus_if.o_sclk;
        end
        c_end_sdata = bus_if.o_sdata;
        c_end_sclk  = bus_if.o_sclk;
        c_end_ovf   = bus_if.o_ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.i_load = 1'b1; bus_if.i_latch = 1'b1; bus_if.i_data = 8'h5A; bus_if.i_blank = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus_if.i_load = 1'b0; bus_if.i_latch = 1'b0;
        checks++;
        if ({bus_if.o_busy, bus_if.o_sdata, bus_if.o_sclk, bus_if.o_rclk, bus_if.o_ovf} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {bus_if.o_busy, bus_if.o_sdata, bus_if.o_sclk, bus_if.o_rclk, bus_if.o_ovf});
        end
        rst = 1'b0;
        collect(4, -1, 0, 8'h00);
        checks++;
        if (c_busy !== 0 || c_sclk_hi !== 0 || c_rclk !== 0) begin
            failures++;
            $display("FAIL reset_idle got busy=%0d sclk=%0d rclk=%0d exp=0,0,0", c_busy, c_sclk_hi, c_rclk);
        end
    endtask

    task automatic test_shift_a5();
        bus_if.i_data = 8'hA5; bus_if.i_load = 1'b1;
        collect(40, -1, 0, 8'h00);
        checks++;
        if (c_busy !== 32 || c_busy_first !== 0 || c_busy_last !== 31) begin
            failures++;
            $display("FAIL a5_busy got cnt=%0d first=%0d last=%0d exp=32,0,31", c_busy, c_busy_first, c_busy_last);
        end
        checks++;
        if (c_edges !== 8) begin
            failures++;
            $display("FAIL a5_edges got=%0d exp=8", c_edges);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (c_t[k] !== 2 + 4 * k) begin
                failures++;
                $display("FAIL a5_edge_time[%0d] got=%0d exp=%0d", k, c_t[k], 2 + 4 * k);
            end
        end
        checks++;
        if (c_word !== 8'hA5) begin
            failures++;
            $display("FAIL a5_stream got=%h exp=a5", c_word);
        end
        checks++;
        if (c_end_sdata !== 1'b0 || c_end_sclk !== 1'b0 || c_rclk !== 0) begin
            failures++;
            $display("FAIL a5_idle_end got sdata=%b sclk=%b rclk=%0d exp=0,0,0", c_end_sdata, c_end_sclk, c_rclk);
        end
    endtask

    task automatic test_latch_idle();
        bus_if.i_latch = 1'b1;
        collect(6, -1, 0, 8'h00);
        checks++;
        if (c_rclk !== 2 || c_rclk_first !== 0 || c_rclk_last !== 1) begin
            failures++;
            $display("FAIL latch_rclk got cnt=%0d first=%0d last=%0d exp=2,0,1", c_rclk, c_rclk_first, c_rclk_last);
        end
        checks++;
        if (c_busy !== 2 || c_busy_first !== 0) begin
            failures++;
            $display("FAIL latch_busy got cnt=%0d first=%0d exp=2,0", c_busy, c_busy_first);
        end
        checks++;
        if (c_sclk_hi !== 0) begin
            failures++;
            $display("FAIL latch_no_sclk got=%0d exp=0", c_sclk_hi);
        end
    endtask

    task automatic test_latch_during_shift();
        bus_if.i_data = 8'h3C; bus_if.i_load = 1'b1;
        collect(44, 10, 1, 8'h00);
        checks++;
        if (c_word !== 8'h3C || c_edges !== 8) begin
            failures++;
            $display("FAIL mid_latch_stream got=%h edges=%0d exp=3c,8", c_word, c_edges);
        end
        checks++;
        if (c_busy !== 34 || c_busy_first !== 0 || c_busy_last !== 33) begin
            failures++;
            $display("FAIL mid_latch_busy got cnt=%0d first=%0d last=%0d exp=34,0,33", c_busy, c_busy_first, c_busy_last);
        end
        checks++;
        if (c_rclk !== 2 || c_rclk_first !== 32) begin
            failures++;
            $display("FAIL mid_latch_rclk got cnt=%0d first=%0d exp=2,32", c_rclk, c_rclk_first);
        end
    endtask

    task automatic test_load_latch_same();
        bus_if.i_data = 8'hFF; bus_if.i_load = 1'b1; bus_if.i_latch = 1'b1;
        collect(44, -1, 0, 8'h00);
        checks++;
        if (c_rclk !== 2 || c_rclk_first !== 0) begin
            failures++;
            $display("FAIL same_rclk got cnt=%0d first=%0d exp=2,0", c_rclk, c_rclk_first);
        end
        checks++;
        if (c_edges !== 8 || c_word !== 8'hFF || c_t[0] !== 4) begin
            failures++;
            $display("FAIL same_stream got=%h edges=%0d first_edge=%0d exp=ff,8,4", c_word, c_edges, c_t[0]);
        end
        checks++;
        if (c_busy !== 34 || c_busy_last !== 33) begin
            failures++;
            $display("FAIL same_busy got cnt=%0d last=%0d exp=34,33", c_busy, c_busy_last);
        end
        checks++;
        if (c_end_ovf !== 1'b0) begin
            failures++;
            $display("FAIL same_ovf got=%b exp=0", c_end_ovf);
        end
    endtask

    task automatic test_overflow_blank();
        bus_if.i_data = 8'h81; bus_if.i_load = 1'b1;
        collect(40, 5, 2, 8'h00);
        checks++;
        if (c_end_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=1", c_end_ovf);
        end
        checks++;
        if (c_word !== 8'h81 || c_busy !== 32) begin
            failures++;
            $display("FAIL ovf_stream got=%h busy=%0d exp=81,32", c_word, c_busy);
        end
        bus_if.i_data = 8'hFF; bus_if.i_load = 1'b1; bus_if.i_blank = 1'b1;
        collect(40, -1, 0, 8'h00);
        checks++;
        if (c_edges !== 8 || c_word !== 8'h00) begin
            failures++;
            $display("FAIL blank_stream got=%h edges=%0d exp=00,8", c_word, c_edges);
        end
        checks++;
        if (c_end_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=1", c_end_ovf);
        end
    endtask

    task automatic test_reset_mid();
        bus_if.i_data = 8'hF0; bus_if.i_load = 1'b1;
        collect(20, 9, 3, 8'h00);
        checks++;
        if (c_snap !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_outputs got busy/sclk/rclk/ovf=%b exp=0000", c_snap);
        end
        checks++;
        if (c_edges !== 2 || c_busy_last !== 8) begin
            failures++;
            $display("FAIL rst_mid_stop got edges=%0d busy_last=%0d exp=2,8", c_edges, c_busy_last);
        end
        bus_if.i_data = 8'h0F; bus_if.i_load = 1'b1;
        collect(40, -1, 0, 8'h00);
        checks++;
        if (c_word !== 8'h0F || c_edges !== 8 || c_busy !== 32) begin
            failures++;
            $display("FAIL rst_fresh_stream got=%h edges=%0d busy=%0d exp=0f,8,32", c_word, c_edges, c_busy);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus_if.i_data = 8'h00;
        bus_if.i_load = 1'b0;
        bus_if.i_latch = 1'b0;
        bus_if.i_blank = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_shift_a5();
        test_latch_idle();
        test_latch_during_shift();
        test_load_latch_same();
        test_overflow_blank();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
